// File: rtl/serdesphy_pll_pkg.sv
// serdesphy_pll_pkg: shared types and constants for the PLL
// frequency-acquisition controller.
package serdesphy_pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    MEASURE,
    EVAL,
    FAIL
  } pll_state_t;

  localparam logic [7:0] CTRL_MIN  = 8'h40;
  localparam logic [7:0] CTRL_MAX  = 8'hC0;
  localparam logic [7:0] CTRL_INIT = 8'h80;

  localparam logic [7:0] STEP_BIG    = 8'd4;
  localparam logic [7:0] STEP_SMALL  = 8'd1;
  localparam logic [8:0] STEP_THRESH = 9'd8;

  localparam logic [2:0] RAIL_LIMIT = 3'd4;

  function automatic logic [8:0] abs9(input logic [8:0] v);
    return v[8] ? (~v + 9'd1) : v;
  endfunction

endpackage

// File: rtl/serdesphy_pll_freq_cnt.sv
// serdesphy_pll_freq_cnt: synchronizes VCO feedback/ready and counts
// feedback rising edges over a 2^WINDOW_LOG2 cycle window.
module serdesphy_pll_freq_cnt
  import serdesphy_pll_pkg::*;
#(
  parameter int WINDOW_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vco_fb,
  input  logic       vco_ready,
  input  logic       measure,
  output logic [7:0] count,
  output logic       window_done,
  output logic       ready_sync
);

  logic [1:0]             fb_sync;
  logic [1:0]             rdy_sync;
  logic                   fb_prev;
  logic                   fb_event;
  logic [WINDOW_LOG2-1:0] win_q;

  assign fb_event    = fb_sync[1] & ~fb_prev;
  assign window_done = measure & (&win_q);
  assign ready_sync  = rdy_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sync  <= '0;
      rdy_sync <= '0;
      fb_prev  <= 1'b0;
      win_q    <= '0;
      count    <= '0;
    end else begin
      fb_sync  <= {fb_sync[0], vco_fb};
      rdy_sync <= {rdy_sync[0], vco_ready};
      fb_prev  <= fb_sync[1];
      // held clear outside MEASURE, so EVAL sees a frozen count
      if (!measure) begin
        win_q <= '0;
        count <= '0;
      end else begin
        win_q <= win_q + WINDOW_LOG2'(1);
        if (fb_event && count != 8'hFF)
          count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/serdesphy_ana_pll_ctrl.sv
// serdesphy_ana_pll_ctrl: VCO enable/ready handshake, frequency
// measurement loop, control-word stepping and lock/fail tracking.
module serdesphy_ana_pll_ctrl
  import serdesphy_pll_pkg::*;
#(
  parameter int WINDOW_LOG2 = 6,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int RDY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_en,
  input  logic [7:0] fb_target,
  input  logic       vco_fb,
  input  logic       vco_ready,
  output logic       vco_enable,
  output logic [7:0] vco_control,
  output logic       pll_lock,
  output logic       pll_fail
);

  localparam logic [8:0] TOL9     = 9'(TOL);
  localparam logic [2:0] LOCK_N   = 3'(LOCK_COUNT);
  localparam logic [7:0] TMO_LAST = 8'(RDY_TIMEOUT - 1);

  pll_state_t state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic       lock_q, lock_d;
  logic [2:0] good_q, good_d;
  logic [2:0] rail_q, rail_d;
  logic [7:0] timer_q, timer_d;

  logic [7:0] count;
  logic       window_done;
  logic       ready_sync;

  logic [8:0] err;
  logic [8:0] mag;
  logic       in_tol;
  logic [7:0] step;
  logic [8:0] ctrl_up;
  logic [7:0] ctrl_dn;
  logic [7:0] ctrl_next;
  logic       at_rail;
  logic [2:0] good_inc;
  logic [2:0] rail_inc;

  serdesphy_pll_freq_cnt #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_freq_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .vco_fb     (vco_fb),
    .vco_ready  (vco_ready),
    .measure    (state_q == MEASURE),
    .count      (count),
    .window_done(window_done),
    .ready_sync (ready_sync)
  );

  // err sign bit set means the VCO runs slow: step control upward
  always_comb begin
    err      = {1'b0, count} - {1'b0, fb_target};
    mag      = abs9(err);
    in_tol   = (mag <= TOL9);
    step     = (mag > STEP_THRESH) ? STEP_BIG : STEP_SMALL;
    ctrl_up  = {1'b0, ctrl_q} + {1'b0, step};
    ctrl_dn  = ctrl_q - step;
    good_inc = (good_q >= LOCK_N) ? good_q : good_q + 3'd1;
    rail_inc = rail_q + 3'd1;
    if (err[8]) begin
      ctrl_next = (ctrl_up > {1'b0, CTRL_MAX}) ? CTRL_MAX : ctrl_up[7:0];
      at_rail   = (ctrl_q == CTRL_MAX);
    end else begin
      ctrl_next = (ctrl_dn < CTRL_MIN) ? CTRL_MIN : ctrl_dn;
      at_rail   = (ctrl_q == CTRL_MIN);
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    lock_d  = lock_q;
    good_d  = good_q;
    rail_d  = rail_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pll_en) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        timer_d = timer_q + 8'd1;
        if (ready_sync) state_d = MEASURE;
        else if (timer_q == TMO_LAST) state_d = FAIL;
      end
      MEASURE, EVAL: begin
        if (!ready_sync) begin
          state_d = WAIT_RDY;
          lock_d  = 1'b0;
          good_d  = '0;
          timer_d = '0;
        end else if (state_q == MEASURE) begin
          if (window_done) state_d = EVAL;
        end else begin
          state_d = MEASURE;
          if (in_tol) begin
            good_d = good_inc;
            lock_d = (good_inc >= LOCK_N);
            rail_d = '0;
          end else begin
            good_d = '0;
            lock_d = 1'b0;
            ctrl_d = ctrl_next;
            rail_d = at_rail ? rail_inc : 3'd0;
            if (at_rail && rail_inc == RAIL_LIMIT) state_d = FAIL;
          end
        end
      end
      FAIL: begin
        lock_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (!pll_en) begin
      state_d = IDLE;
      ctrl_d  = CTRL_INIT;
      lock_d  = 1'b0;
      good_d  = '0;
      rail_d  = '0;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= CTRL_INIT;
      lock_q  <= 1'b0;
      good_q  <= '0;
      rail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      lock_q  <= lock_d;
      good_q  <= good_d;
      rail_q  <= rail_d;
      timer_q <= timer_d;
    end
  end

  assign vco_enable  = (state_q == WAIT_RDY) || (state_q == MEASURE) ||
                       (state_q == EVAL);
  assign vco_control = ctrl_q;
  assign pll_lock    = lock_q;
  assign pll_fail    = (state_q == FAIL);

endmodule

// File: tb/tb_serdesphy_ana_pll_ctrl.sv
// tb_serdesphy_ana_pll_ctrl: directed bench with a VCO model giving
// vco_control>>1 feedback edges per 512-cycle window.
module tb_serdesphy_ana_pll_ctrl;

  localparam int WLOG = 9;
  localparam int WIN  = 1 << WLOG;
  localparam int ITER = WIN + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_en;
  logic [7:0] fb_target;
  logic       vco_fb = 1'b0;
  logic       vco_ready;
  logic       vco_enable;
  logic [7:0] vco_control;
  logic       pll_lock;
  logic       pll_fail;

  int checks = 0;
  int failures = 0;
  int acc = 0;

  serdesphy_ana_pll_ctrl #(
    .WINDOW_LOG2(WLOG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_en     (pll_en),
    .fb_target  (fb_target),
    .vco_fb     (vco_fb),
    .vco_ready  (vco_ready),
    .vco_enable (vco_enable),
    .vco_control(vco_control),
    .pll_lock   (pll_lock),
    .pll_fail   (pll_fail)
  );

  always #5 clk = ~clk;

  // phase accumulator: 2n toggles per WIN cycles, exactly periodic
  always @(negedge clk) begin
    if (vco_enable !== 1'b1) begin
      acc = 0;
      vco_fb = 1'b0;
    end else begin
      acc = acc + 2 * int'(vco_control >> 1);
      if (acc >= WIN) begin
        acc = acc - WIN;
        vco_fb = ~vco_fb;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ctrl_change(input int limit, output int n);
    logic [7:0] p;
    p = vco_control;
    n = 0;
    while (vco_control === p && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_lock(input logic val, input int limit,
                           output int n);
    n = 0;
    while (pll_lock !== val && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fail(input int limit, output int n);
    n = 0;
    while (pll_fail !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] saved;

    rst_n = 1'b0;
    pll_en = 1'b0;
    vco_ready = 1'b0;
    fb_target = 8'd80;
    repeat (3) tick();
    chk("rst_enable", vco_enable, 1'b0);
    chk("rst_control", vco_control, 8'h80);
    chk("rst_lock", pll_lock, 1'b0);
    chk("rst_fail", pll_fail, 1'b0);
    rst_n = 1'b1;
    tick();

    // acquisition toward 80 edges: coarse +4 steps first
    vco_ready = 1'b1;
    pll_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ctrl_change(2 * ITER, n);
      chk("ramp_step", vco_control, 8'h84 + 8'(4 * k));
      if (k == 1) chk("iter_len", n, ITER);
    end
    wait_lock(1'b1, 30000, n);
    chk("lock_80", pll_lock, 1'b1);
    chk("ctrl_80_range",
        (vco_control >= 8'h9E && vco_control <= 8'hA1), 1'b1);
    chk("lock_enable", vco_enable, 1'b1);
    chk("lock_nofail", pll_fail, 1'b0);

    // ready drop while locked
    saved = vco_control;
    vco_ready = 1'b0;
    wait_lock(1'b0, 6, n);
    chk("rdy_drop_lat", (n >= 1 && n <= 3), 1'b1);
    repeat (10 - n) tick();
    chk("rdy_drop_ctrl", vco_control, saved);
    chk("rdy_drop_en", vco_enable, 1'b1);
    chk("rdy_drop_lock", pll_lock, 1'b0);
    vco_ready = 1'b1;
    wait_lock(1'b1, 5000, n);
    chk("relock", pll_lock, 1'b1);
    chk("relock_ctrl", vco_control, saved);

    // retarget 80 -> 70 while locked
    saved = vco_control;
    fb_target = 8'd70;
    wait_lock(1'b0, 2 * ITER, n);
    chk("retarget_drop", pll_lock, 1'b0);
    chk("retarget_step", vco_control, saved - 8'd4);
    wait_lock(1'b1, 20000, n);
    chk("lock_70", pll_lock, 1'b1);
    chk("ctrl_70_range",
        (vco_control >= 8'h8A && vco_control <= 8'h8F), 1'b1);

    // pll_en low mid-MEASURE
    repeat (100) tick();
    pll_en = 1'b0;
    tick();
    chk("en_low_ctrl", vco_control, 8'h80);
    chk("en_low_enable", vco_enable, 1'b0);
    chk("en_low_lock", pll_lock, 1'b0);

    // unreachable target: rail at CTRL_MAX then fail
    fb_target = 8'd240;
    pll_en = 1'b1;
    n = 0;
    while (vco_control !== 8'hC0 && n < 20000) begin
      tick();
      n++;
    end
    chk("rail_reach", vco_control, 8'hC0);
    wait_fail(3000, n);
    chk("rail_fail_time", n, 4 * ITER);
    chk("rail_fail", pll_fail, 1'b1);
    chk("rail_enable", vco_enable, 1'b0);
    chk("rail_lock", pll_lock, 1'b0);
    chk("rail_ctrl", vco_control, 8'hC0);
    pll_en = 1'b0;
    tick();
    chk("fail_clear", pll_fail, 1'b0);

    // ready never arrives
    vco_ready = 1'b0;
    repeat (3) tick();
    pll_en = 1'b1;
    tick();
    chk("tmo_enable", vco_enable, 1'b1);
    wait_fail(400, n);
    chk("tmo_cycles", n, 255);
    chk("tmo_enable_off", vco_enable, 1'b0);

    // async reset mid-MEASURE
    pll_en = 1'b0;
    tick();
    fb_target = 8'd80;
    vco_ready = 1'b1;
    pll_en = 1'b1;
    wait_ctrl_change(2 * ITER, n);
    chk("rst2_first", vco_control, 8'h84);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("rst2_ctrl", vco_control, 8'h80);
    chk("rst2_enable", vco_enable, 1'b0);
    chk("rst2_lock", pll_lock, 1'b0);
    chk("rst2_fail", pll_fail, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serdesphy_ana_pll_ctrl.md
# serdesphy_ana_pll_ctrl

Digital frequency-acquisition controller for the SerDes PHY PLL VCO. It enables the VCO and waits for its ready flag. It then counts VCO feedback edges over a fixed reference-clock window and steps the 8-bit VCO control word until the measured count matches a programmed target, after which it asserts lock. It sits between the PHY control registers and the analog VCO model, driving the VCO's enable and control inputs and consuming its output clock and ready flag.

## Interface
- WINDOW_LOG2, 6: measurement window = 2^WINDOW_LOG2 clk cycles (64)
- TOL, 1: lock tolerance, edges per window
- LOCK_COUNT, 4: consecutive in-tolerance windows required for lock
- CTRL_MIN / CTRL_MAX / CTRL_INIT, 8'h40 / 8'hC0 / 8'h80: control clamp bounds and start value
- RDY_TIMEOUT, 255: clk cycles allowed for vco_ready
- clk  in  1  reference clock
- rst_n  in  1  asynchronous active-low reset
- pll_en  in  1  acquisition enable (level)
- fb_target  in  8  expected feedback edges per window
- vco_fb  in  1  VCO output, asynchronous to clk
- vco_ready  in  1  VCO stable flag, asynchronous to clk
- vco_enable  out  1  VCO enable
- vco_control  out  8  VCO control word
- pll_lock  out  1  frequency locked
- pll_fail  out  1  acquisition failed (sticky until pll_en low)

## Operation
- Reset values: vco_enable=0, vco_control=CTRL_INIT, pll_lock=0, pll_fail=0, state IDLE, all counters 0.
- vco_fb and vco_ready each pass through a 2-FF synchronizer. A rising edge of synced vco_fb is an fb event.
- States:
  - IDLE: outputs at reset values. On pll_en=1 -> WAIT_RDY.
  - WAIT_RDY: vco_enable=1. Timer counts up. On synced vco_ready=1 -> MEASURE. When the timer reaches RDY_TIMEOUT -> FAIL.
  - MEASURE: window counter runs 2^WINDOW_LOG2 cycles. The edge counter (8-bit) increments per fb event and saturates at 255. On the last window cycle -> EVAL.
  - EVAL (1 cycle): err = count − fb_target, 9-bit signed.
    - If |err| ≤ TOL: good_cnt++ (saturating). pll_lock=1 once good_cnt reaches LOCK_COUNT. vco_control unchanged.
    - Otherwise: good_cnt=0 and pll_lock=0. step = 4 if |err|>8, else 1. vco_control −= step if err>0, += step if err<0. The result is clamped to [CTRL_MIN, CTRL_MAX].
    - Rail counter: incremented when vco_control is already at a bound and err pushes beyond it. Cleared by any other EVAL result. When it reaches 4 -> FAIL.
    - Otherwise -> MEASURE. Edge and window counters are cleared on entry.
  - FAIL: pll_fail=1, vco_enable=0, pll_lock=0. Exit only via pll_en=0.
- pll_en=0 in any state: next cycle IDLE, all outputs at reset values.
- Synced vco_ready falling in MEASURE or EVAL: pll_lock=0, good_cnt=0, -> WAIT_RDY. The timer restarts and vco_control is held.
- fb events arriving during EVAL are discarded.
- Tracking continues while locked. A single out-of-tolerance window drops pll_lock.

## Timing
- One iteration = 2^WINDOW_LOG2 + 1 cycles (65 at default).
- vco_control and pll_lock are registered and update on the clk edge leaving EVAL.
- vco_fb and vco_ready reach the FSM with 2-cycle synchronizer latency.
- pll_fail asserts on the edge entering FAIL.
- Minimum time to lock from IDLE: 1 + 2 (ready sync) + LOCK_COUNT × 65 cycles.
- vco_fb high/low periods must each be ≥ 2 clk cycles. Faster input is undercounted; this is not detected.

## Structure
- Shared package serdesphy_pll_pkg: state enum (IDLE, WAIT_RDY, MEASURE, EVAL, FAIL), CTRL_MIN/MAX/INIT, step constants (4, 1, threshold 8), rail-fail limit 4.
- Sub-module serdesphy_pll_freq_cnt: synchronizer, edge detect, window counter and saturating edge counter. Outputs count plus a one-cycle window_done pulse.
- Top holds the FSM, error/step/clamp arithmetic and lock/rail counters.

## Test plan
- Bench VCO model gives edges/window = vco_control>>1. Set fb_target=80, pll_en=1 -> vco_control ramps 0x80 by +4 steps to 0x90, then +1 steps. Settles in 0x9E–0xA1. pll_lock rises after 4 good windows.
- fb_target=240 -> vco_control clamps at 0xC0. pll_fail=1 after the 4th EVAL at the rail. vco_enable=0.
- vco_ready held 0 -> pll_fail=1 exactly RDY_TIMEOUT cycles after entering WAIT_RDY.
- Locked, then vco_ready drops for 10 cycles -> pll_lock=0 within 3 cycles. Returns to WAIT_RDY. vco_control is held and lock is reacquired.
- Locked, then fb_target changes 80 -> 70 -> lock drops at the next EVAL. vco_control decreases until re-lock.
- rst_n or pll_en low mid-MEASURE -> all outputs at reset values (vco_control=0x80) immediately / next cycle respectively.
